// File: rtl/button_pkg.sv
// button_pkg: gesture FSM state type, controller event indices and a sizing helper
package button_pkg;

    typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND} gesture_state_t;

    localparam int PRESS   = 0;
    localparam int RELEASE = 1;
    localparam int SHORT   = 2;
    localparam int DOUBLE  = 3;
    localparam int LONG    = 4;
    localparam int REPEAT  = 5;
    localparam int NUM_EV  = 6;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/button_gesture_btn_edge.sv
// btn_edge: registers the button level and decodes its rising and falling edges
// Ports: clk, rst (async, active-high); i_btn level in;
//        o_held registered level, o_rise / o_fall combinational edge strobes
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_held,
    output logic o_rise,
    output logic o_fall
);

    logic r_btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_btn_q <= 1'b0;
        else     r_btn_q <= i_btn;
    end

    assign o_held = r_btn_q;
    assign o_rise = i_btn & ~r_btn_q;
    assign o_fall = ~i_btn & r_btn_q;

endmodule

// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button level into single-cycle gesture events
// Ports: clk, rst (async, active-high); btn_in debounced level;
//        press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse
//        are registered 1-cycle pulses; held is the registered button level
module button_gesture
    import button_pkg::*;
#(
    parameter int LONG_CYCLES       = 50_000_000,
    parameter int DOUBLE_GAP_CYCLES = 12_500_000,
    parameter int REPEAT_CYCLES     = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int CW = $clog2(max3(LONG_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES) + 1) + 1;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LONG = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] C_GAP  = CW'(DOUBLE_GAP_CYCLES);
    localparam logic [CW-1:0] C_REP  = CW'(REPEAT_CYCLES);

    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("LONG_CYCLES must be >= 2");
    end
    if (DOUBLE_GAP_CYCLES < 2) begin : g_bad_gap
        $error("DOUBLE_GAP_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rep
        $error("REPEAT_CYCLES must be >= 1");
    end

    logic w_rise, w_fall;
    gesture_state_t r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [NUM_EV-1:0] r_ev, w_ev;

    btn_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_in),
        .o_held (held),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Edge checks precede threshold checks so a fall beats the long threshold
    // and a rise beats the gap timeout on the same edge.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ev    = '0;
        case (r_state)
            IDLE: if (w_rise) begin
                w_state = PRESSED; w_cnt = C_ONE; w_ev[PRESS] = 1'b1;
            end
            PRESSED: if (w_fall) begin
                w_state = GAP; w_cnt = C_ONE; w_ev[RELEASE] = 1'b1;
            end else if (r_cnt == C_LONG) begin
                w_state = LONG_HELD; w_cnt = C_ONE; w_ev[LONG] = 1'b1;
            end else w_cnt = r_cnt + 1'b1;
            LONG_HELD: if (w_fall) begin
                w_state = IDLE; w_ev[RELEASE] = 1'b1;
            end else if (r_cnt == C_REP) begin
                w_cnt = C_ONE; w_ev[REPEAT] = 1'b1;
            end else w_cnt = r_cnt + 1'b1;
            GAP: if (w_rise) begin
                w_state = SECOND; w_cnt = C_ONE; w_ev[PRESS] = 1'b1;
            end else if (r_cnt == C_GAP) begin
                w_state = IDLE; w_ev[SHORT] = 1'b1;
            end else w_cnt = r_cnt + 1'b1;
            SECOND: if (w_fall) begin
                w_state = IDLE; w_ev[RELEASE] = 1'b1; w_ev[DOUBLE] = 1'b1;
            end else if (r_cnt == C_LONG) begin
                w_state = LONG_HELD; w_cnt = C_ONE; w_ev[LONG] = 1'b1;
            end else w_cnt = r_cnt + 1'b1;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ev    <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ev    <= w_ev;
        end
    end

    assign press_pulse   = r_ev[PRESS];
    assign release_pulse = r_ev[RELEASE];
    assign short_press   = r_ev[SHORT];
    assign double_click  = r_ev[DOUBLE];
    assign long_press    = r_ev[LONG];
    assign repeat_pulse  = r_ev[REPEAT];

endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed and random button streams checked against a run-length gesture model
module tb_button_gesture;
    import button_pkg::*;

    localparam int L = 8;
    localparam int G = 4;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_in = 1'b0;
    logic press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse, held;

    int checks = 0;
    int errors = 0;

    // Model: lengths of the current high/low runs plus whether the last short
    // first press is still waiting for a second one.
    bit m_prev, m_armed, m_second;
    int m_hi, m_lo;
    logic [NUM_EV-1:0] e;
    int seen [NUM_EV];

    button_gesture #(
        .LONG_CYCLES       (L),
        .DOUBLE_GAP_CYCLES (G),
        .REPEAT_CYCLES     (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero();
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_short", short_press, 0);
        chk("rst_double", double_click, 0);
        chk("rst_long", long_press, 0);
        chk("rst_repeat", repeat_pulse, 0);
        chk("rst_held", held, 0);
    endtask

    task automatic model_reset();
        m_prev = 0; m_armed = 0; m_second = 0; m_hi = 0; m_lo = 0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NUM_EV; i++) seen[i] = 0;
    endtask

    task automatic model(input bit s);
        e = '0;
        if (s && !m_prev) begin
            e[PRESS] = 1'b1;
            m_hi = 1;
            m_second = m_armed && m_lo <= G;
            m_armed = 0;
        end else if (s) begin
            m_hi++;
            e[LONG] = (m_hi == L + 1);
            e[REPEAT] = (m_hi > L + 1) && ((m_hi - L - 1) % R == 0);
        end else if (m_prev) begin
            e[RELEASE] = 1'b1;
            m_lo = 1;
            e[DOUBLE] = m_second && m_hi <= L;
            m_armed = !m_second && m_hi <= L;
        end else begin
            m_lo++;
            if (m_armed && m_lo == G + 1) begin
                e[SHORT] = 1'b1;
                m_armed = 0;
            end
        end
        m_prev = s;
    endtask

    task automatic step(input bit b);
        btn_in = b;
        @(posedge clk);
        model(b);
        #1;
        chk("press_pulse", press_pulse, e[PRESS]);
        chk("release_pulse", release_pulse, e[RELEASE]);
        chk("short_press", short_press, e[SHORT]);
        chk("double_click", double_click, e[DOUBLE]);
        chk("long_press", long_press, e[LONG]);
        chk("repeat_pulse", repeat_pulse, e[REPEAT]);
        chk("held", held, m_prev);
        seen[PRESS]   += int'(press_pulse);
        seen[RELEASE] += int'(release_pulse);
        seen[SHORT]   += int'(short_press);
        seen[DOUBLE]  += int'(double_click);
        seen[LONG]    += int'(long_press);
        seen[REPEAT]  += int'(repeat_pulse);
    endtask

    task automatic steps(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset(input bit b);
        #2 rst = 1'b1;
        btn_in = b;
        #1 chk_zero();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit lvl;
        model_reset();
        clear_seen();
        do_reset(1'b0);

        // short press
        steps(1, 3); steps(0, 10);
        chk("short_cnt_press", seen[PRESS], 1);
        chk("short_cnt_release", seen[RELEASE], 1);
        chk("short_cnt_short", seen[SHORT], 1);
        chk("short_cnt_other", seen[DOUBLE] + seen[LONG] + seen[REPEAT], 0);

        // double click
        clear_seen();
        steps(1, 2); steps(0, 2); steps(1, 2); steps(0, 10);
        chk("dbl_cnt_press", seen[PRESS], 2);
        chk("dbl_cnt_double", seen[DOUBLE], 1);
        chk("dbl_cnt_short", seen[SHORT], 0);

        // long press with repeats
        clear_seen();
        steps(1, 20); steps(0, 8);
        chk("long_cnt_long", seen[LONG], 1);
        chk("long_cnt_repeat", seen[REPEAT], 3);
        chk("long_cnt_release", seen[RELEASE], 1);
        chk("long_cnt_short", seen[SHORT] + seen[DOUBLE], 0);

        // low sampled exactly at the long threshold edge
        clear_seen();
        steps(1, L); steps(0, 10);
        chk("bnd_long_cnt_long", seen[LONG], 0);
        chk("bnd_long_cnt_short", seen[SHORT], 1);

        // re-press exactly at the gap timeout edge
        clear_seen();
        steps(1, 2); steps(0, G); steps(1, 2); steps(0, 8);
        chk("bnd_gap_cnt_double", seen[DOUBLE], 1);
        chk("bnd_gap_cnt_short", seen[SHORT], 0);

        // second press held into long press
        clear_seen();
        steps(1, 2); steps(0, 2); steps(1, 15); steps(0, 8);
        chk("sec_long_cnt_long", seen[LONG], 1);
        chk("sec_long_cnt_double", seen[DOUBLE], 0);
        chk("sec_long_cnt_repeat", seen[REPEAT], 2);

        // reset mid-gap discards the pending short press
        clear_seen();
        steps(1, 3); steps(0, 2);
        clear_seen();
        do_reset(1'b0);
        steps(0, 8);
        chk("rst_gap_cnt_short", seen[SHORT], 0);

        // button held through reset release
        clear_seen();
        do_reset(1'b1);
        steps(1, 2); steps(0, 8);
        chk("rst_hi_cnt_press", seen[PRESS], 1);

        // random run-length stream with occasional resets
        lvl = 1'b0;
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 19) == 0) do_reset(1'($urandom_range(0, 1)));
            lvl = ~lvl;
            steps(lvl, $urandom_range(1, 14));
        end
        steps(0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
